// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction prefetch queue between instruction memory and decode
// Optional feature macro: FETCH_STALL_COUNT_EN adds the stall_count output.
module fetch_queue #(
  parameter int WORD_WIDTH = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_rd,
  output logic [WORD_WIDTH-1:0] mem_addr,
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic                  redirect,
  input  logic [WORD_WIDTH-1:0] redirect_addr,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [WORD_WIDTH-1:0] out_pc,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [WORD_WIDTH-1:0] stall_count
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [WORD_WIDTH-1:0] fetch_pc;
  logic [WORD_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  squash;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      occupancy;
  logic [WORD_WIDTH-1:0] instr_mem [DEPTH];
  logic [WORD_WIDTH-1:0] pc_mem    [DEPTH];
  logic [CNT_W:0]        credits_used;
  logic                  push;
  logic                  pop;

  // Issue, push and pop decisions; redirect overrides all three.
  // Issue is gated by reset so the memory sees no strobe while held in reset,
  // and it counts the in-flight read as a used slot so a late return always fits.
  always_comb begin
    credits_used = {1'b0, occupancy} + (CNT_W + 1)'(inflight);
    mem_rd       = rst_n & ~redirect & (credits_used < DEPTH_C);
    push         = inflight & ~squash & ~redirect;
    pop          = out_valid & out_ready & ~redirect;
  end

  assign mem_addr  = fetch_pc;
  assign out_valid = (occupancy != '0);
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Fetch PC and in-flight read tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= '0;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      squash      <= 1'b0;
    end else begin
      inflight <= mem_rd;
      squash   <= redirect & inflight;
      if (redirect) begin
        fetch_pc <= redirect_addr;
      end else if (mem_rd) begin
        fetch_pc    <= fetch_pc + WORD_WIDTH'(1);
        inflight_pc <= fetch_pc;
      end
    end
  end

  // FIFO pointers and occupancy; a redirect empties the queue outright.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else if (redirect) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads as zero until filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        instr_mem[i] <= '0;
        pc_mem[i]    <= '0;
      end
    end else if (push) begin
      instr_mem[wr_ptr] <= mem_data;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  // Saturating count of cycles where decode was ready but had nothing to take.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (out_ready && !out_valid && !redirect && (stall_count != '1)) begin
      stall_count <= stall_count + WORD_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - self-checking bench for fetch_queue with a queue-based reference model
module tb_fetch_queue;
  localparam int W = 16;
  localparam int D = 4;

  typedef struct packed {
    logic [W-1:0] instr;
    logic [W-1:0] pc;
  } ent_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mem_rd;
  logic [W-1:0] mem_addr;
  logic [W-1:0] mem_data = '0;
  logic         redirect = 1'b0;
  logic [W-1:0] redirect_addr = '0;
  logic [W-1:0] out_instr;
  logic [W-1:0] out_pc;
  logic         out_valid;
  logic         out_ready = 1'b0;
`ifdef FETCH_STALL_COUNT_EN
  logic [W-1:0] stall_count;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  ent_t         q[$];
  logic [W-1:0] m_pc;
  logic [W-1:0] m_ipc;
  bit           m_infl;
  bit           m_sq;
  logic [W-1:0] m_stall;
  bit           e_rd;
  bit           e_valid;

  always #5 clk = ~clk;

  fetch_queue #(.WORD_WIDTH(W), .DEPTH(D)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .redirect(redirect),
    .redirect_addr(redirect_addr),
    .out_instr(out_instr),
    .out_pc(out_pc),
    .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_count(stall_count)
`endif
  );

  // synchronous 1-cycle memory: word = addr ^ A5A5, noise when not read
  always @(posedge clk) begin
    if (mem_rd) mem_data <= mem_addr ^ 16'hA5A5;
    else        mem_data <= W'($urandom);
  end

  task automatic model_reset();
    q.delete();
    m_pc = '0; m_ipc = '0; m_infl = 0; m_sq = 0; m_stall = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic drive(input bit rdy, input bit redir, input logic [W-1:0] raddr);
    out_ready = rdy; redirect = redir; redirect_addr = raddr;
    #1;
    e_rd    = rst_n && !redir && ((q.size() + int'(m_infl)) < D);
    e_valid = (q.size() != 0);
  endtask

  task automatic advance();
    bit   pop, push;
    ent_t e;
    @(posedge clk);
    pop  = e_valid && out_ready && !redirect;
    push = m_infl && !m_sq && !redirect;
    if (out_ready && !e_valid && !redirect && m_stall != 16'hFFFF) m_stall = m_stall + 1'b1;
    if (redirect) begin
      q.delete();
      m_sq   = m_infl;
      m_infl = 0;
      m_pc   = redirect_addr;
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        e.instr = m_ipc ^ 16'hA5A5;
        e.pc    = m_ipc;
        q.push_back(e);
      end
      m_sq = 0;
      if (e_rd) begin
        m_ipc  = m_pc;
        m_pc   = m_pc + 1'b1;
        m_infl = 1;
      end else begin
        m_infl = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    for (int k = 0; k < 6; k++) begin drive(1, 0, '0); advance(); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL reset_mem_rd: got %b expected 0", mem_rd); end
    checks++; if (out_instr !== 16'h0000) begin errors++; $display("FAIL reset_instr: got %h expected 0000", out_instr); end
    checks++; if (out_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", out_pc); end
    checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_addr: got %h expected 0000", mem_addr); end
`ifdef FETCH_STALL_COUNT_EN
    checks++; if (stall_count !== 16'h0000) begin errors++; $display("FAIL reset_stall: got %h expected 0000", stall_count); end
`endif
  endtask

  task automatic test_stream();
    logic [W-1:0] ep;
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      drive(1, 0, '0);
      checks++; if (mem_rd !== 1'b1 || mem_addr !== W'(k)) begin
        errors++; $display("FAIL stream_issue: got rd=%b addr=%h expected rd=1 addr=%h", mem_rd, mem_addr, W'(k));
      end
      if (k >= 2) begin
        ep = W'(k - 2);
        checks++; if (out_valid !== 1'b1 || out_pc !== ep || out_instr !== (ep ^ 16'hA5A5)) begin
          errors++; $display("FAIL stream_out: got v=%b pc=%h instr=%h expected v=1 pc=%h instr=%h", out_valid, out_pc, out_instr, ep, ep ^ 16'hA5A5);
        end
      end else begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_latency: got v=%b expected 0 at cycle %0d", out_valid, k); end
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int issues = 0;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, '0);
      if (mem_rd === 1'b1) begin
        checks++; if (mem_addr !== W'(issues)) begin errors++; $display("FAIL bp_addr: got %h expected %h", mem_addr, W'(issues)); end
        issues++;
      end
      advance();
    end
    checks++; if (issues != D) begin errors++; $display("FAIL bp_issue_count: got %0d expected %0d", issues, D); end
    drive(0, 0, '0);
    checks++; if (mem_rd !== 1'b0 || mem_addr !== 16'h0004 || out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      errors++; $display("FAIL bp_full: got rd=%b addr=%h v=%b pc=%h expected rd=0 addr=0004 v=1 pc=0000", mem_rd, mem_addr, out_valid, out_pc);
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, '0);
      checks++; if (out_valid !== 1'b1 || out_pc !== W'(i)) begin
        errors++; $display("FAIL bp_drain: got v=%b pc=%h expected v=1 pc=%h", out_valid, out_pc, W'(i));
      end
      if (i == 0) begin
        checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL bp_credit: got rd=%b expected 0", mem_rd); end
      end
      if (i == 1) begin
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0004) begin
          errors++; $display("FAIL bp_resume: got rd=%b addr=%h expected rd=1 addr=0004", mem_rd, mem_addr);
        end
      end
      advance();
    end
  endtask

  task automatic test_redirect();
    logic [W-1:0] exp_pc [2];
    int got = 0;
    exp_pc[0] = 16'h0040; exp_pc[1] = 16'h0041;
    apply_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, '0); advance(); end
    drive(0, 0, '0);
    checks++; if (mem_rd !== 1'b0 || out_valid !== 1'b1 || out_pc !== 16'h0000) begin
      errors++; $display("FAIL redir_setup: got rd=%b v=%b pc=%h expected rd=0 v=1 pc=0000", mem_rd, out_valid, out_pc);
    end
    drive(1, 1, 16'h0040);
    checks++; if (mem_rd !== 1'b0) begin errors++; $display("FAIL redir_no_issue: got %b expected 0", mem_rd); end
    advance();
    drive(1, 0, '0);
    checks++; if (out_valid !== 1'b0 || mem_rd !== 1'b1 || mem_addr !== 16'h0040) begin
      errors++; $display("FAIL redir_flush: got v=%b rd=%b addr=%h expected v=0 rd=1 addr=0040", out_valid, mem_rd, mem_addr);
    end
    for (int i = 0; i < 10 && got < 2; i++) begin
      if (i > 0) drive(1, 0, '0);
      if (out_valid === 1'b1) begin
        checks++; if (out_pc !== exp_pc[got] || out_instr !== (exp_pc[got] ^ 16'hA5A5)) begin
          errors++; $display("FAIL redir_seq: got pc=%h instr=%h expected pc=%h instr=%h", out_pc, out_instr, exp_pc[got], exp_pc[got] ^ 16'hA5A5);
        end
        got++;
      end
      advance();
    end
    checks++; if (got != 2) begin errors++; $display("FAIL redir_timeout: got %0d words expected 2", got); end
  endtask

  task automatic test_wrap();
    logic [W-1:0] exp_pc [4];
    int got = 0;
    exp_pc[0] = 16'hFFFE; exp_pc[1] = 16'hFFFF; exp_pc[2] = 16'h0000; exp_pc[3] = 16'h0001;
    apply_reset();
    drive(1, 1, 16'hFFFE);
    advance();
    for (int i = 0; i < 12 && got < 4; i++) begin
      drive(1, 0, '0);
      if (out_valid === 1'b1) begin
        checks++; if (out_pc !== exp_pc[got]) begin
          errors++; $display("FAIL wrap_seq: got pc=%h expected pc=%h", out_pc, exp_pc[got]);
        end
        got++;
      end
      advance();
    end
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_timeout: got %0d words expected 4", got); end
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, '0); advance(); end
    drive(0, 0, '0);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_setup: got v=%b expected 1", out_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || mem_rd !== 1'b0 || out_pc !== 16'h0000) begin
      errors++; $display("FAIL mid_reset: got v=%b rd=%b pc=%h expected v=0 rd=0 pc=0000", out_valid, mem_rd, out_pc);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, '0);
      checks++; if (mem_rd !== 1'b1 || mem_addr !== W'(k)) begin
        errors++; $display("FAIL mid_restart: got rd=%b addr=%h expected rd=1 addr=%h", mem_rd, mem_addr, W'(k));
      end
      advance();
    end
  endtask

  task automatic test_random();
    bit           rdy, redir;
    logic [W-1:0] raddr;
    apply_reset();
    for (int c = 0; c < 500; c++) begin
      rdy   = ($urandom_range(3, 0) != 0);
      redir = ($urandom_range(9, 0) == 0);
      raddr = ($urandom_range(3, 0) == 0) ? 16'hFFFD : W'($urandom);
      drive(rdy, redir, raddr);
      checks++; if (mem_rd !== e_rd || mem_addr !== m_pc) begin
        errors++; $display("FAIL rand_issue: cycle %0d got rd=%b addr=%h expected rd=%b addr=%h", c, mem_rd, mem_addr, e_rd, m_pc);
      end
      checks++; if (out_valid !== e_valid) begin
        errors++; $display("FAIL rand_valid: cycle %0d got %b expected %b", c, out_valid, e_valid);
      end
      if (e_valid) begin
        checks++; if (out_pc !== q[0].pc || out_instr !== q[0].instr) begin
          errors++; $display("FAIL rand_head: cycle %0d got pc=%h instr=%h expected pc=%h instr=%h", c, out_pc, out_instr, q[0].pc, q[0].instr);
        end
      end
`ifdef FETCH_STALL_COUNT_EN
      checks++; if (stall_count !== m_stall) begin
        errors++; $display("FAIL rand_stall: cycle %0d got %0d expected %0d", c, stall_count, m_stall);
      end
`endif
      advance();
    end
  endtask

`ifdef FETCH_STALL_COUNT_EN
  task automatic test_stall_count();
    apply_reset();
    for (int i = 0; i < 10; i++) begin drive(1, 0, '0); advance(); end
    checks++; if (stall_count !== 16'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", stall_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_reset_midstream();
    test_random();
`ifdef FETCH_STALL_COUNT_EN
    test_stall_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

endmodule
